// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF/MEM pipeline ports, the arbiter and the memory.
// slave is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_done_o;
   logic [DW-1:0] if_rdata_o;
   logic          if_stall_o;

   logic          d_req_i;
   logic          d_we_i;
   logic [AW-1:0] d_addr_i;
   logic [DW-1:0] d_wdata_i;
   logic          d_done_o;
   logic [DW-1:0] d_rdata_o;
   logic          d_stall_o;

   logic          err_o;

   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_ack_i;
   logic [DW-1:0] mem_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
      input  mem_ack_i, mem_rdata_i,
      output if_done_o, if_rdata_o, if_stall_o,
      output d_done_o, d_rdata_o, d_stall_o,
      output err_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output if_req_i, if_addr_i,
      output d_req_i, d_we_i, d_addr_i, d_wdata_i,
      output mem_ack_i, mem_rdata_i,
      input  if_done_o, if_rdata_o, if_stall_o,
      input  d_done_o, d_rdata_o, d_stall_o,
      input  err_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch port and the data port,
// with data priority, a fetch anti-starvation streak limit and a watchdog abort.
module mem_port_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned MAX_STREAK = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input logic               clk_i,
   input logic               rst_i,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
   localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [3:0]    streak_q, streak_d;
   logic [7:0]    wdog_q, wdog_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          if_done_q, if_done_d;
   logic          d_done_q, d_done_d;
   logic          err_q, err_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          if_elig, d_elig;
   logic          grant_if, grant_d;

   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      wdog_d      = wdog_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;
      err_d       = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      grant_if    = 1'b0;
      grant_d     = 1'b0;

      // A port whose done is pulsing this cycle cannot be re-granted yet.
      if_elig = bus.if_req_i & ~if_done_q;
      d_elig  = bus.d_req_i & ~d_done_q;

      unique case (state_q)
         IDLE: begin
            if (if_elig && d_elig) begin
               if (streak_q == STREAK_MAX) grant_if = 1'b1;
               else                        grant_d  = 1'b1;
            end else if (if_elig) begin
               grant_if = 1'b1;
            end else if (d_elig) begin
               grant_d = 1'b1;
            end

            if (grant_if) begin
               state_d     = BUSY_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.if_addr_i;
               mem_wdata_d = '0;
               streak_d    = '0;
               wdog_d      = '0;
            end else if (grant_d) begin
               state_d     = BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.d_we_i;
               mem_addr_d  = bus.d_addr_i;
               mem_wdata_d = bus.d_wdata_i;
               wdog_d      = '0;
               if (!if_elig)                    streak_d = '0;
               else if (streak_q != STREAK_MAX) streak_d = streak_q + 4'd1;
            end
         end

         BUSY_IF, BUSY_D: begin
            // Ack in the final watchdog cycle takes precedence over the abort.
            if (bus.mem_ack_i) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == BUSY_IF) begin
                  if_done_d  = 1'b1;
                  if_rdata_d = bus.mem_rdata_i;
               end else begin
                  d_done_d  = 1'b1;
                  d_rdata_d = mem_we_q ? '0 : bus.mem_rdata_i;
               end
            end else if (wdog_q == WDOG_LAST) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               err_d     = 1'b1;
               if (state_q == BUSY_IF) begin
                  if_done_d  = 1'b1;
                  if_rdata_d = '0;
               end else begin
                  d_done_d  = 1'b1;
                  d_rdata_d = '0;
               end
            end else begin
               wdog_d = wdog_q + 8'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         wdog_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         err_q       <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         wdog_q      <= wdog_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
         err_q       <= err_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign bus.if_done_o   = if_done_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.if_stall_o  = bus.if_req_i & ~if_done_q;
   assign bus.d_done_o    = d_done_q;
   assign bus.d_rdata_o   = d_rdata_q;
   assign bus.d_stall_o   = bus.d_req_i & ~d_done_q;
   assign bus.err_o       = err_q;
   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with constant expectations, then
// random traffic compared against a transaction-level reference model.
module tb_mem_port_arbiter;
   localparam int unsigned AW         = 32;
   localparam int unsigned DW         = 32;
   localparam int unsigned MAX_STREAK = 4;
   localparam int unsigned TIMEOUT    = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int nvec = 0;
   int nerr = 0;

   // Reference model: owner 0 = memory free, 1 = fetch, 2 = data.
   int            m_owner, m_wait, m_streak;
   logic          m_if_done, m_d_done, m_err, m_mem_req, m_mem_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_if_rd, m_d_rd;

   logic          s_rst, s_if_req, s_d_req, s_d_we, s_ack;
   logic [AW-1:0] s_if_addr, s_d_addr;
   logic [DW-1:0] s_d_wdata, s_rdata;

   task automatic model_reset();
      m_owner = 0; m_wait = 0; m_streak = 0;
      m_if_done = 0; m_d_done = 0; m_err = 0; m_mem_req = 0; m_mem_we = 0;
      m_addr = '0; m_wdata = '0; m_if_rd = '0; m_d_rd = '0;
   endtask

   task automatic model_step();
      logic          ef, ed, fin;
      int            pick;
      logic [DW-1:0] rd;
      if (s_rst) begin
         model_reset();
         return;
      end
      ef = s_if_req && !m_if_done;
      ed = s_d_req && !m_d_done;
      m_if_done = 0; m_d_done = 0; m_err = 0;
      fin = 0; rd = '0;
      if (m_owner == 0) begin
         pick = 0;
         if (ef && ed) pick = (m_streak == MAX_STREAK) ? 1 : 2;
         else if (ef)  pick = 1;
         else if (ed)  pick = 2;
         if (pick == 1) begin
            m_streak = 0; m_mem_we = 0; m_addr = s_if_addr; m_wdata = '0;
         end else if (pick == 2) begin
            m_streak = ef ? ((m_streak < int'(MAX_STREAK)) ? m_streak + 1 : m_streak) : 0;
            m_mem_we = s_d_we; m_addr = s_d_addr; m_wdata = s_d_wdata;
         end
         if (pick != 0) begin
            m_owner = pick; m_wait = 0; m_mem_req = 1;
         end
      end else begin
         if (s_ack) begin
            fin = 1;
            rd  = (m_owner == 2 && m_mem_we) ? '0 : s_rdata;
         end else begin
            m_wait++;
            if (m_wait >= int'(TIMEOUT)) begin
               fin = 1; m_err = 1; rd = '0;
            end
         end
         if (fin) begin
            if (m_owner == 1) begin m_if_done = 1; m_if_rd = rd; end
            else              begin m_d_done  = 1; m_d_rd  = rd; end
            m_owner = 0; m_mem_req = 0;
         end
      end
   endtask

   task automatic tick();
      s_rst = rst; s_if_req = bus.if_req_i; s_if_addr = bus.if_addr_i;
      s_d_req = bus.d_req_i; s_d_we = bus.d_we_i; s_d_addr = bus.d_addr_i;
      s_d_wdata = bus.d_wdata_i; s_ack = bus.mem_ack_i; s_rdata = bus.mem_rdata_i;
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      tick();
      tick();
      nvec++;
      if ({bus.if_done_o, bus.d_done_o, bus.err_o, bus.mem_req_o, bus.mem_we_o, bus.if_stall_o, bus.d_stall_o} !== 7'b0) begin
         nerr++;
         $display("FAIL reset_flags: got %b exp %b", {bus.if_done_o, bus.d_done_o, bus.err_o, bus.mem_req_o, bus.mem_we_o, bus.if_stall_o, bus.d_stall_o}, 7'b0);
      end
      nvec++;
      if ({bus.mem_addr_o, bus.mem_wdata_o, bus.if_rdata_o, bus.d_rdata_o} !== 128'b0) begin
         nerr++;
         $display("FAIL reset_buses: got %h exp 0", {bus.mem_addr_o, bus.mem_wdata_o, bus.if_rdata_o, bus.d_rdata_o});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_fetch();
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
      #1;
      nvec++;
      if ({bus.if_stall_o, bus.mem_req_o} !== 2'b10) begin
         nerr++; $display("FAIL single_fetch_c0: got %b exp %b", {bus.if_stall_o, bus.mem_req_o}, 2'b10);
      end
      tick();
      nvec++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.if_done_o, bus.if_stall_o} !== {1'b1, 1'b0, 32'h40, 1'b0, 1'b1}) begin
         nerr++; $display("FAIL single_fetch_c1: got %h exp %h", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.if_done_o, bus.if_stall_o}, {1'b1, 1'b0, 32'h40, 1'b0, 1'b1});
      end
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h8C010004;
      tick();
      nvec++;
      if ({bus.if_done_o, bus.mem_req_o, bus.err_o, bus.if_stall_o, bus.if_rdata_o} !== {4'b1000, 32'h8C010004}) begin
         nerr++; $display("FAIL single_fetch_c2: got %h exp %h", {bus.if_done_o, bus.mem_req_o, bus.err_o, bus.if_stall_o, bus.if_rdata_o}, {4'b1000, 32'h8C010004});
      end
      bus.if_req_i = 1'b0; bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
      tick();
      nvec++;
      if ({bus.if_done_o, bus.mem_req_o, bus.if_rdata_o} !== {2'b00, 32'h8C010004}) begin
         nerr++; $display("FAIL single_fetch_c3: got %h exp %h", {bus.if_done_o, bus.mem_req_o, bus.if_rdata_o}, {2'b00, 32'h8C010004});
      end
   endtask

   task automatic test_back_to_back();
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
      tick();
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h11111111;
      tick();
      nvec++;
      if ({bus.if_done_o, bus.mem_req_o} !== 2'b10) begin
         nerr++; $display("FAIL b2b_done: got %b exp %b", {bus.if_done_o, bus.mem_req_o}, 2'b10);
      end
      bus.if_addr_i = 32'h44; bus.mem_ack_i = 1'b0;
      tick();
      nvec++;
      if ({bus.if_done_o, bus.mem_req_o, bus.if_stall_o} !== 3'b001) begin
         nerr++; $display("FAIL b2b_masked: got %b exp %b", {bus.if_done_o, bus.mem_req_o, bus.if_stall_o}, 3'b001);
      end
      tick();
      nvec++;
      if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h44}) begin
         nerr++; $display("FAIL b2b_regrant: got %h exp %h", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, 32'h44});
      end
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h22222222;
      tick();
      nvec++;
      if ({bus.if_done_o, bus.if_rdata_o} !== {1'b1, 32'h22222222}) begin
         nerr++; $display("FAIL b2b_second_done: got %h exp %h", {bus.if_done_o, bus.if_rdata_o}, {1'b1, 32'h22222222});
      end
      bus.if_req_i = 1'b0; bus.mem_ack_i = 1'b0;
      tick();
   endtask

   task automatic test_fetch_and_write();
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'h100; bus.d_wdata_i = 32'hDEADBEEF;
      tick();
      nvec++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.if_stall_o, bus.d_stall_o} !== {2'b11, 32'h100, 32'hDEADBEEF, 2'b11}) begin
         nerr++; $display("FAIL fw_data_grant: got %h exp %h", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.if_stall_o, bus.d_stall_o}, {2'b11, 32'h100, 32'hDEADBEEF, 2'b11});
      end
      tick();
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h12345678;
      tick();
      nvec++;
      if ({bus.d_done_o, bus.if_done_o, bus.err_o, bus.mem_req_o, bus.d_stall_o, bus.d_rdata_o} !== {5'b10000, 32'h0}) begin
         nerr++; $display("FAIL fw_data_done_c3: got %h exp %h", {bus.d_done_o, bus.if_done_o, bus.err_o, bus.mem_req_o, bus.d_stall_o, bus.d_rdata_o}, {5'b10000, 32'h0});
      end
      bus.d_req_i = 1'b0; bus.mem_ack_i = 1'b0;
      tick();
      nvec++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {2'b10, 32'h200, 32'h0}) begin
         nerr++; $display("FAIL fw_fetch_grant: got %h exp %h", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}, {2'b10, 32'h200, 32'h0});
      end
      tick();
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hCAFEF00D;
      tick();
      nvec++;
      if ({bus.if_done_o, bus.d_done_o, bus.if_rdata_o} !== {2'b10, 32'hCAFEF00D}) begin
         nerr++; $display("FAIL fw_fetch_done_c6: got %h exp %h", {bus.if_done_o, bus.d_done_o, bus.if_rdata_o}, {2'b10, 32'hCAFEF00D});
      end
      bus.if_req_i = 1'b0; bus.mem_ack_i = 1'b0;
      tick();
   endtask

   task automatic test_streak();
      logic          exp_we;
      logic [AW-1:0] exp_addr;
      bus.d_we_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         bus.if_req_i = 1'b1; bus.if_addr_i = 32'h80 + 32'(k * 4);
         bus.d_req_i = 1'b1; bus.d_addr_i = 32'h300 + 32'(k * 4); bus.d_wdata_i = 32'(k);
         tick();
         exp_we   = (k % 5) != 4;
         exp_addr = exp_we ? 32'h300 + 32'(k * 4) : 32'h80 + 32'(k * 4);
         nvec++;
         if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o} !== {1'b1, exp_we, exp_addr}) begin
            nerr++; $display("FAIL streak_grant_%0d: got %h exp %h", k, {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o}, {1'b1, exp_we, exp_addr});
         end
         bus.mem_ack_i = 1'b1;
         tick();
         bus.mem_ack_i = 1'b0;
         nvec++;
         if ({bus.if_done_o, bus.d_done_o} !== {~exp_we, exp_we}) begin
            nerr++; $display("FAIL streak_done_%0d: got %b exp %b", k, {bus.if_done_o, bus.d_done_o}, {~exp_we, exp_we});
         end
         bus.if_req_i = 1'b0; bus.d_req_i = 1'b0;
         tick();
      end
   endtask

   task automatic test_timeout();
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h500;
      tick();
      for (int c = 1; c <= 8; c++) begin
         nvec++;
         if (bus.mem_req_o !== 1'b1) begin
            nerr++; $display("FAIL late_ack_req_c%0d: got %b exp 1", c, bus.mem_req_o);
         end
         if (c == 8) begin bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h0BADF00D; end
         tick();
      end
      nvec++;
      if ({bus.d_done_o, bus.err_o, bus.mem_req_o, bus.d_rdata_o} !== {3'b100, 32'h0BADF00D}) begin
         nerr++; $display("FAIL late_ack_done: got %h exp %h", {bus.d_done_o, bus.err_o, bus.mem_req_o, bus.d_rdata_o}, {3'b100, 32'h0BADF00D});
      end
      bus.d_req_i = 1'b0; bus.mem_ack_i = 1'b0;
      tick();
      bus.d_req_i = 1'b1; bus.d_addr_i = 32'h504;
      tick();
      for (int c = 1; c <= 8; c++) begin
         nvec++;
         if ({bus.mem_req_o, bus.d_done_o} !== 2'b10) begin
            nerr++; $display("FAIL timeout_req_c%0d: got %b exp %b", c, {bus.mem_req_o, bus.d_done_o}, 2'b10);
         end
         tick();
      end
      nvec++;
      if ({bus.d_done_o, bus.err_o, bus.mem_req_o, bus.if_done_o, bus.d_rdata_o} !== {4'b1100, 32'h0}) begin
         nerr++; $display("FAIL timeout_abort: got %h exp %h", {bus.d_done_o, bus.err_o, bus.mem_req_o, bus.if_done_o, bus.d_rdata_o}, {4'b1100, 32'h0});
      end
      bus.d_req_i = 1'b0;
      tick();
      nvec++;
      if ({bus.d_done_o, bus.err_o, bus.mem_req_o} !== 3'b000) begin
         nerr++; $display("FAIL timeout_after: got %b exp %b", {bus.d_done_o, bus.err_o, bus.mem_req_o}, 3'b000);
      end
   endtask

   task automatic test_reset_mid();
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'h600; bus.d_wdata_i = 32'h55;
      tick();
      tick();
      nvec++;
      if (bus.mem_req_o !== 1'b1) begin
         nerr++; $display("FAIL rstmid_busy: got %b exp 1", bus.mem_req_o);
      end
      rst = 1'b1;
      model_reset();
      #1;
      nvec++;
      if ({bus.mem_req_o, bus.d_done_o} !== 2'b00) begin
         nerr++; $display("FAIL rstmid_async_drop: got %b exp %b", {bus.mem_req_o, bus.d_done_o}, 2'b00);
      end
      tick();
      rst = 1'b0;
      tick();
      nvec++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.d_done_o} !== {2'b11, 32'h600, 1'b0}) begin
         nerr++; $display("FAIL rstmid_regrant: got %h exp %h", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.d_done_o}, {2'b11, 32'h600, 1'b0});
      end
      bus.mem_ack_i = 1'b1;
      tick();
      nvec++;
      if ({bus.d_done_o, bus.err_o} !== 2'b10) begin
         nerr++; $display("FAIL rstmid_done: got %b exp %b", {bus.d_done_o, bus.err_o}, 2'b10);
      end
      bus.d_req_i = 1'b0; bus.mem_ack_i = 1'b0;
      tick();
   endtask

   task automatic test_random();
      bit f_act = 0;
      bit d_act = 0;
      rst = 1'b1;
      model_reset();
      tick();
      rst = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         nvec++;
         if ({bus.if_done_o, bus.d_done_o, bus.err_o, bus.mem_req_o} !== {m_if_done, m_d_done, m_err, m_mem_req}) begin
            nerr++; $display("FAIL rand_ctrl @%0d: got %b exp %b", n, {bus.if_done_o, bus.d_done_o, bus.err_o, bus.mem_req_o}, {m_if_done, m_d_done, m_err, m_mem_req});
         end
         nvec++;
         if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {m_mem_we, m_addr, m_wdata}) begin
            nerr++; $display("FAIL rand_membus @%0d: got %h exp %h", n, {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}, {m_mem_we, m_addr, m_wdata});
         end
         nvec++;
         if ({bus.if_rdata_o, bus.d_rdata_o} !== {m_if_rd, m_d_rd}) begin
            nerr++; $display("FAIL rand_rdata @%0d: got %h exp %h", n, {bus.if_rdata_o, bus.d_rdata_o}, {m_if_rd, m_d_rd});
         end
         nvec++;
         if ((bus.if_done_o && bus.d_done_o) || (bus.err_o && !(bus.if_done_o || bus.d_done_o))) begin
            nerr++; $display("FAIL rand_invariant @%0d: got done=%b%b err=%b exp one done, err only with done", n, bus.if_done_o, bus.d_done_o, bus.err_o);
         end
         if (bus.if_done_o) f_act = 0;
         if (bus.d_done_o)  d_act = 0;
         if (!f_act) begin
            if ($urandom_range(0, 2) == 0) begin
               f_act = 1; bus.if_req_i = 1'b1; bus.if_addr_i = $urandom;
            end else begin
               bus.if_req_i = 1'b0;
            end
         end
         if (!d_act) begin
            if ($urandom_range(0, 2) == 0) begin
               d_act = 1; bus.d_req_i = 1'b1; bus.d_we_i = 1'($urandom_range(0, 1));
               bus.d_addr_i = $urandom; bus.d_wdata_i = $urandom;
            end else begin
               bus.d_req_i = 1'b0;
            end
         end
         bus.mem_ack_i   = ($urandom_range(0, 3) == 0);
         bus.mem_rdata_i = $urandom;
         #1;
         nvec++;
         if ({bus.if_stall_o, bus.d_stall_o} !== {bus.if_req_i & ~m_if_done, bus.d_req_i & ~m_d_done}) begin
            nerr++; $display("FAIL rand_stall @%0d: got %b exp %b", n, {bus.if_stall_o, bus.d_stall_o}, {bus.if_req_i & ~m_if_done, bus.d_req_i & ~m_d_done});
         end
         tick();
      end
      bus.if_req_i = 1'b0; bus.d_req_i = 1'b0; bus.mem_ack_i = 1'b0;
   endtask

   initial begin
      bus.if_req_i = 1'b0; bus.if_addr_i = '0;
      bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
      bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_fetch_and_write();
      test_streak();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified memory between the pipeline's instruction-fetch port (read-only) and data-memory port (read/write). Each requester sees a req/done handshake and a stall signal. The downstream memory uses a variable-latency req/ack handshake. Data accesses normally win, but a streak counter prevents fetch starvation, and a watchdog aborts memory transactions that never complete. The block sits between the IF/MEM pipeline stages and the memory model.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_STREAK, 4, consecutive contested data grants before fetch is forced to win (1..15)
- TIMEOUT, 255, cycles without ack before abort (1..255)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request; hold with if_addr_i stable until if_done_o
- if_addr_i  in  AW  fetch address
- if_done_o  out  1  one-cycle completion pulse to fetch
- if_rdata_o  out  DW  fetch read data, valid with if_done_o, held until next fetch done
- if_stall_o  out  1  if_req_i & ~if_done_o (combinational)
- d_req_i  in  1  data request; hold with d_we_i, d_addr_i and d_wdata_i stable until d_done_o
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  AW  data address
- d_wdata_i  in  DW  write data
- d_done_o  out  1  one-cycle completion pulse to data port
- d_rdata_o  out  DW  data read result, valid with d_done_o; 0 for writes
- d_stall_o  out  1  d_req_i & ~d_done_o (combinational)
- err_o  out  1  high with the done pulse of an aborted transaction
- mem_req_o  out  1  memory request, held until ack or abort
- mem_we_o, mem_addr_o, mem_wdata_o  out  1/AW/DW  registered copy of the granted request
- mem_ack_i  in  1  memory completion; sampled only while mem_req_o = 1
- mem_rdata_i  in  DW  valid when mem_ack_i = 1

## Operation
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE arbitration (each cycle):
  - Eligible requester: req high and its done_o low this cycle. A port whose done is pulsing is masked.
  - Only one eligible requester: grant it.
  - Both eligible: grant data unless streak == MAX_STREAK; in that case grant fetch.
- On a grant:
  - Register the address, we and wdata. Fetch forces we = 0 and wdata = 0.
  - Move to BUSY_IF or BUSY_D.
  - mem_req_o goes high the next cycle.
- Streak counter (4-bit):
  - Data grant while fetch was also eligible: +1.
  - Data grant while fetch was not eligible: reset to 0.
  - Any fetch grant: reset to 0.
  - Saturates at MAX_STREAK.
- BUSY_x while mem_ack_i = 1:
  - Latch mem_rdata_i into x_rdata_o (d_rdata_o = 0 for writes).
  - Pulse x_done_o the next cycle; drop mem_req_o; return to IDLE.
- Watchdog (8-bit):
  - Clears on every grant and increments each BUSY cycle with ack low.
  - On reaching TIMEOUT, the next cycle: mem_req_o = 0, x_done_o = 1, err_o = 1, rdata = 0, back to IDLE.
  - Ack in the same cycle the count reaches TIMEOUT wins: normal completion, no error.
- mem_ack_i is ignored in IDLE.
- Reset values: all outputs 0, state IDLE, streak 0, watchdog 0.
- Reset mid-transaction: mem_req_o drops asynchronously; no done pulse is issued and the transaction is lost.

## Timing
- Minimum latency:
  - Request seen in cycle 0.
  - mem_req_o in cycle 1.
  - Ack in cycle 1.
  - done_o in cycle 2.
- In general, done_o rises one cycle after the ack cycle.
- Back-to-back: in the done cycle of one port, IDLE may grant the other port. The masked port can be granted again one cycle after its done.
- Throughput per port: at most one transaction every 3 cycles.
- Stall outputs are combinational: the pipeline freezes in the same cycle req rises and releases in the done cycle.
- At most one done_o is high in any cycle. err_o is never high without a done.

## Test plan
- Single fetch, addr 0x40, ack in the first mem_req cycle with rdata 0x8C010004:
  - mem_req_o high cycle 1 only.
  - if_done_o and if_rdata_o = 0x8C010004 in cycle 2.
  - if_stall_o high cycles 0–1.
- Simultaneous fetch and data write (addr 0x100, data 0xDEADBEEF), 2-cycle ack latency:
  - Data served first with mem_we_o = 1; d_done_o in cycle 3, d_rdata_o = 0.
  - Fetch granted in cycle 3; if_done_o in cycle 6.
- MAX_STREAK = 4, fetch held high, data re-requesting continuously:
  - Data wins 4 grants.
  - 5th grant goes to fetch even with d_req_i high; streak returns to 0.
- TIMEOUT = 8, ack never asserted on a data read:
  - mem_req_o high 8 cycles.
  - Next cycle: d_done_o = 1, err_o = 1, d_rdata_o = 0, mem_req_o = 0.
  - A second case with ack in the 8th cycle completes normally, err_o = 0.
- rst_i pulsed mid-BUSY_D:
  - mem_req_o falls asynchronously; no d_done_o.
  - After release, a held d_req_i is re-granted from IDLE with streak 0.
- Fetch req held through its done cycle:
  - No re-grant in the done cycle.
  - New transaction starts the following cycle with the new address.
